// File: rtl/command_executor.sv
// command_executor: executes decoded parser commands against the text RAM; owns cursor and scroll origin.
// Optional build macro AUTO_WRAP_EN enables deferred auto-wrap at the last column.
// commandType codes: 0 INPUT, 1 IND, 2 NEL, 3 RI, 4 CUU, 5 CUD, 6 CUF, 7 CUB, 8 CUP.
module command_executor #(
    parameter int COLS   = 80,
    parameter int ROWS   = 24,
    parameter int COL_W  = $clog2(COLS),
    parameter int ROW_W  = $clog2(ROWS),
    parameter int ADDR_W = $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commandReady,
    input  logic [3:0]        commandType,
    input  logic [7:0]        Pn1,
    input  logic [7:0]        Pn2,
    input  logic [7:0]        Pchar,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [7:0]        ramData,
    output logic [ROW_W-1:0]  cursorRow,
    output logic [COL_W-1:0]  cursorCol,
    output logic [ROW_W-1:0]  topLine,
    output logic              busy,
    output logic              overflow
);
    localparam logic [3:0] CMD_INPUT = 4'd0;
    localparam logic [3:0] CMD_IND   = 4'd1;
    localparam logic [3:0] CMD_NEL   = 4'd2;
    localparam logic [3:0] CMD_RI    = 4'd3;
    localparam logic [3:0] CMD_CUU   = 4'd4;
    localparam logic [3:0] CMD_CUD   = 4'd5;
    localparam logic [3:0] CMD_CUF   = 4'd6;
    localparam logic [3:0] CMD_CUB   = 4'd7;
    localparam logic [3:0] CMD_CUP   = 4'd8;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [COL_W:0]   CLR_END  = (COL_W+1)'(COLS);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;

    state_t              state_q, state_d;
    logic                buf_valid_q, buf_valid_d;
    logic [3:0]          buf_type_q, buf_type_d;
    logic [7:0]          buf_pn1_q, buf_pn1_d, buf_pn2_q, buf_pn2_d, buf_char_q, buf_char_d;
    logic [ROW_W-1:0]    row_q, row_d, top_q, top_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                wrap_q, wrap_d;
    logic                we_q, we_d, busy_q, busy_d, ovf_q, ovf_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, clr_base_q, clr_base_d, pend_addr_q, pend_addr_d;
    logic [7:0]          data_q, data_d, pend_data_q, pend_data_d;
    logic [COL_W:0]      clr_cnt_q, clr_cnt_d;
    logic                pend_q, pend_d;

    // Execution results for the buffered command
    logic [8:0]          n1, n2, row9, col9, cud_sum, cuf_sum;
    logic                printable;
    logic [ROW_W-1:0]    ex_row, ex_top, ex_clr_row, wr_row;
    logic [COL_W-1:0]    ex_col, wr_col;
    logic                ex_wrap, ex_we, ex_scroll, ex_defer, do_ind, do_ri, wrap_write;
    logic [ADDR_W-1:0]   ex_addr, ex_clr_base;

    function automatic logic [ADDR_W-1:0] phys_addr(input logic [ROW_W-1:0] r,
                                                    input logic [ROW_W-1:0] t,
                                                    input logic [COL_W-1:0] c);
        logic [ROW_W:0] s;
        s = {1'b0, r} + {1'b0, t};
        if (s >= (ROW_W+1)'(ROWS))
            s = s - (ROW_W+1)'(ROWS);
        return ADDR_W'(s) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    assign n1        = (buf_pn1_q == 8'd0) ? 9'd1 : {1'b0, buf_pn1_q};
    assign n2        = (buf_pn2_q == 8'd0) ? 9'd1 : {1'b0, buf_pn2_q};
    assign row9      = 9'(row_q);
    assign col9      = 9'(col_q);
    assign cud_sum   = row9 + n1;
    assign cuf_sum   = col9 + n1;
    assign printable = (buf_char_q >= 8'h20) && (buf_char_q <= 8'h7E);

    always_comb begin
        ex_row     = row_q;
        ex_col     = col_q;
        ex_top     = top_q;
        ex_wrap    = wrap_q;
        ex_we      = 1'b0;
        ex_scroll  = 1'b0;
        ex_clr_row = top_q;
        ex_defer   = 1'b0;
        do_ind     = 1'b0;
        do_ri      = 1'b0;
        wrap_write = 1'b0;
        wr_row     = row_q;
        wr_col     = col_q;
        case (buf_type_q)
            CMD_INPUT: begin
                if (printable) begin
`ifdef AUTO_WRAP_EN
                    if (wrap_q) begin
                        do_ind     = 1'b1;
                        wrap_write = 1'b1;
                        ex_wrap    = 1'b0;
                        ex_col     = COL_W'(1);
                    end else begin
                        ex_we = 1'b1;
                        if (col_q == COL_LAST)
                            ex_wrap = 1'b1;
                        else
                            ex_col = col_q + COL_W'(1);
                    end
`else
                    ex_we = 1'b1;
                    if (col_q != COL_LAST)
                        ex_col = col_q + COL_W'(1);
`endif
                end else if (buf_char_q == 8'h0D) begin
                    ex_col  = '0;
                    ex_wrap = 1'b0;
                end else if (buf_char_q == 8'h0A) begin
                    do_ind = 1'b1;
                end else if (buf_char_q == 8'h08) begin
                    ex_col  = (col_q == '0) ? '0 : col_q - COL_W'(1);
                    ex_wrap = 1'b0;
                end
            end
            CMD_IND: do_ind = 1'b1;
            CMD_NEL: begin
                ex_col  = '0;
                ex_wrap = 1'b0;
                do_ind  = 1'b1;
            end
            CMD_RI:  do_ri = 1'b1;
            CMD_CUU: begin
                ex_row  = (n1 > row9) ? '0 : ROW_W'(row9 - n1);
                ex_wrap = 1'b0;
            end
            CMD_CUD: begin
                ex_row  = (cud_sum > 9'(ROW_LAST)) ? ROW_LAST : ROW_W'(cud_sum);
                ex_wrap = 1'b0;
            end
            CMD_CUF: begin
                ex_col  = (cuf_sum > 9'(COL_LAST)) ? COL_LAST : COL_W'(cuf_sum);
                ex_wrap = 1'b0;
            end
            CMD_CUB: begin
                ex_col  = (n1 > col9) ? '0 : COL_W'(col9 - n1);
                ex_wrap = 1'b0;
            end
            CMD_CUP: begin
                ex_row  = (n1 >= 9'(ROWS)) ? ROW_LAST : ROW_W'(n1 - 9'd1);
                ex_col  = (n2 >= 9'(COLS)) ? COL_LAST : COL_W'(n2 - 9'd1);
                ex_wrap = 1'b0;
            end
            default: ;
        endcase
        // Scroll up clears the old top row, which becomes the new bottom line
        if (do_ind) begin
            if (row_q != ROW_LAST) begin
                ex_row = row_q + ROW_W'(1);
            end else begin
                ex_scroll  = 1'b1;
                ex_clr_row = top_q;
                ex_top     = (top_q == ROW_LAST) ? '0 : top_q + ROW_W'(1);
            end
        end
        if (do_ri) begin
            if (row_q != '0) begin
                ex_row = row_q - ROW_W'(1);
            end else begin
                ex_scroll  = 1'b1;
                ex_top     = (top_q == '0) ? ROW_LAST : top_q - ROW_W'(1);
                ex_clr_row = ex_top;
            end
        end
        // A wrapped character lands after the clear so it is not erased by it
        if (wrap_write) begin
            wr_row = ex_row;
            wr_col = '0;
            if (ex_scroll)
                ex_defer = 1'b1;
            else
                ex_we = 1'b1;
        end
    end

    assign ex_addr     = phys_addr(wr_row, ex_top, wr_col);
    assign ex_clr_base = phys_addr(ex_clr_row, '0, '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (buf_valid_q || commandReady) state_d = S_EXEC;
            S_EXEC:  state_d = ex_scroll ? S_CLEAR : S_IDLE;
            S_CLEAR: if (clr_cnt_q == CLR_END && !pend_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_type_d  = buf_type_q;
        buf_pn1_d   = buf_pn1_q;
        buf_pn2_d   = buf_pn2_q;
        buf_char_d  = buf_char_q;
        row_d       = row_q;
        col_d       = col_q;
        top_d       = top_q;
        wrap_d      = wrap_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        ovf_d       = ovf_q;
        clr_base_d  = clr_base_q;
        clr_cnt_d   = clr_cnt_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        if (state_q == S_EXEC) begin
            buf_valid_d = 1'b0;
            row_d       = ex_row;
            col_d       = ex_col;
            top_d       = ex_top;
            wrap_d      = ex_wrap;
            if (ex_we) begin
                we_d   = 1'b1;
                addr_d = ex_addr;
                data_d = buf_char_q;
            end
            // Column 0 of the exposed row is written here; CLEAR covers the rest
            if (ex_scroll) begin
                we_d        = 1'b1;
                addr_d      = ex_clr_base;
                data_d      = 8'h20;
                clr_base_d  = ex_clr_base;
                clr_cnt_d   = (COL_W+1)'(1);
                pend_d      = ex_defer;
                pend_addr_d = ex_addr;
                pend_data_d = buf_char_q;
            end
        end else if (state_q == S_CLEAR) begin
            if (clr_cnt_q != CLR_END) begin
                we_d      = 1'b1;
                addr_d    = clr_base_q + ADDR_W'(clr_cnt_q);
                data_d    = 8'h20;
                clr_cnt_d = clr_cnt_q + (COL_W+1)'(1);
            end else if (pend_q) begin
                we_d   = 1'b1;
                addr_d = pend_addr_q;
                data_d = pend_data_q;
                pend_d = 1'b0;
            end
        end
        if (commandReady) begin
            if (!buf_valid_q) begin
                buf_valid_d = 1'b1;
                buf_type_d  = commandType;
                buf_pn1_d   = Pn1;
                buf_pn2_d   = Pn2;
                buf_char_d  = Pchar;
            end else begin
                ovf_d = 1'b1;
            end
        end
        busy_d = buf_valid_d || (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_type_q  <= '0;
            buf_pn1_q   <= '0;
            buf_pn2_q   <= '0;
            buf_char_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            top_q       <= '0;
            wrap_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            clr_base_q  <= '0;
            clr_cnt_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_type_q  <= buf_type_d;
            buf_pn1_q   <= buf_pn1_d;
            buf_pn2_q   <= buf_pn2_d;
            buf_char_q  <= buf_char_d;
            row_q       <= row_d;
            col_q       <= col_d;
            top_q       <= top_d;
            wrap_q      <= wrap_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            clr_base_q  <= clr_base_d;
            clr_cnt_q   <= clr_cnt_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign ramWe     = we_q;
    assign ramAddr   = addr_q;
    assign ramData   = data_q;
    assign cursorRow = row_q;
    assign cursorCol = col_q;
    assign topLine   = top_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_command_executor.sv
// tb_command_executor: directed and randomized checks of command_executor against a behavioural screen model.
`timescale 1ns/1ps
module tb_command_executor;
    localparam int COLS  = 80;
    localparam int ROWS  = 24;
    localparam int NCELL = COLS * ROWS;
    localparam int LOGN  = 32768;

    localparam logic [3:0] C_INPUT = 4'd0, C_IND = 4'd1, C_NEL = 4'd2, C_RI  = 4'd3, C_CUU = 4'd4,
                           C_CUD   = 4'd5, C_CUF = 4'd6, C_CUB = 4'd7, C_CUP = 4'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        commandReady = 1'b0;
    logic [3:0]  commandType = '0;
    logic [7:0]  Pn1 = '0, Pn2 = '0, Pchar = '0;
    logic        ramWe;
    logic [10:0] ramAddr;
    logic [7:0]  ramData;
    logic [4:0]  cursorRow;
    logic [6:0]  cursorCol;
    logic [4:0]  topLine;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    command_executor dut (
        .clk(clk), .rst(rst), .commandReady(commandReady), .commandType(commandType),
        .Pn1(Pn1), .Pn2(Pn2), .Pchar(Pchar), .ramWe(ramWe), .ramAddr(ramAddr), .ramData(ramData),
        .cursorRow(cursorRow), .cursorCol(cursorCol), .topLine(topLine), .busy(busy), .overflow(overflow)
    );

    // Observed text RAM plus a log of every write, captured mid-cycle
    logic [7:0] ram_obs [NCELL];
    int         wa_log  [LOGN];
    int         wd_log  [LOGN];
    int         wr_count = 0;

    always @(negedge clk) begin
        if (ramWe === 1'b1) begin
            if (ramAddr < 11'(NCELL))
                ram_obs[ramAddr] <= ramData;
            wa_log[wr_count % LOGN] <= int'(ramAddr);
            wd_log[wr_count % LOGN] <= int'(ramData);
            wr_count <= wr_count + 1;
        end
    end

    // Behavioural screen model
    logic [7:0] ram_exp [NCELL];
    int m_row = 0, m_col = 0, m_top = 0, exp_wr = 0;
    bit m_wrap = 1'b0;

    task automatic m_clear(input int prow);
        for (int c = 0; c < COLS; c++) ram_exp[prow*COLS + c] = 8'h20;
        exp_wr += COLS;
    endtask

    task automatic m_ind();
        if (m_row < ROWS-1) m_row++;
        else begin
            m_top = (m_top + 1) % ROWS;
            m_clear((m_top + ROWS - 1) % ROWS);
        end
    endtask

    task automatic m_ri();
        if (m_row > 0) m_row--;
        else begin
            m_top = (m_top + ROWS - 1) % ROWS;
            m_clear(m_top);
        end
    endtask

    task automatic m_write(input int ch);
        ram_exp[((m_row + m_top) % ROWS)*COLS + m_col] = 8'(ch);
        exp_wr++;
    endtask

    task automatic model(input logic [3:0] t, input int p1, input int p2, input int ch);
        int n1, n2;
        n1 = (p1 == 0) ? 1 : p1;
        n2 = (p2 == 0) ? 1 : p2;
        case (t)
            C_INPUT: begin
                if (ch >= 32 && ch <= 126) begin
`ifdef AUTO_WRAP_EN
                    if (m_wrap) begin m_col = 0; m_ind(); m_wrap = 1'b0; end
                    m_write(ch);
                    if (m_col == COLS-1) m_wrap = 1'b1; else m_col++;
`else
                    m_write(ch);
                    if (m_col < COLS-1) m_col++;
`endif
                end else if (ch == 13) begin m_col = 0; m_wrap = 1'b0; end
                else if (ch == 10) m_ind();
                else if (ch == 8) begin m_col = (m_col > 0) ? m_col - 1 : 0; m_wrap = 1'b0; end
            end
            C_IND: m_ind();
            C_NEL: begin m_col = 0; m_wrap = 1'b0; m_ind(); end
            C_RI:  m_ri();
            C_CUU: begin m_row = (m_row - n1 < 0) ? 0 : m_row - n1; m_wrap = 1'b0; end
            C_CUD: begin m_row = (m_row + n1 > ROWS-1) ? ROWS-1 : m_row + n1; m_wrap = 1'b0; end
            C_CUF: begin m_col = (m_col + n1 > COLS-1) ? COLS-1 : m_col + n1; m_wrap = 1'b0; end
            C_CUB: begin m_col = (m_col - n1 < 0) ? 0 : m_col - n1; m_wrap = 1'b0; end
            C_CUP: begin
                m_row = ((n1 < ROWS) ? n1 : ROWS) - 1;
                m_col = ((n2 < COLS) ? n2 : COLS) - 1;
                m_wrap = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] t, input int p1, input int p2, input int ch);
        commandType  = t;
        Pn1          = 8'(p1);
        Pn2          = 8'(p2);
        Pchar        = 8'(ch);
        commandReady = 1'b1;
        tick();
        commandReady = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin tick(); n++; end
        check({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    task automatic compare_state(input string tag);
        int bad;
        bad = 0;
        check({tag, "_row"}, 32'(cursorRow), 32'(m_row));
        check({tag, "_col"}, 32'(cursorCol), 32'(m_col));
        check({tag, "_top"}, 32'(topLine), 32'(m_top));
        check({tag, "_nwrites"}, 32'(wr_count), 32'(exp_wr));
        for (int i = 0; i < NCELL; i++) if (ram_obs[i] !== ram_exp[i]) bad++;
        check({tag, "_ram_bad_cells"}, 32'(bad), 32'(0));
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] t, input int p1, input int p2, input int ch);
        send(t, p1, p2, ch);
        model(t, p1, p2, ch);
        wait_idle(tag);
        compare_state(tag);
    endtask

    // Runs a scrolling command and checks the 80-write clear burst and busy length
    task automatic scroll_burst(input string tag, input logic [3:0] t, input int base);
        int start, cycles, bad;
        start = wr_count;
        send(t, 0, 0, 0);
        model(t, 0, 0, 0);
        cycles = 0;
        while (busy === 1'b1 && cycles < 400) begin cycles++; tick(); end
        check({tag, "_busy_cycles"}, 32'(cycles), 32'(COLS + 1));
        check({tag, "_clear_writes"}, 32'(wr_count - start), 32'(COLS));
        bad = 0;
        for (int i = 0; i < COLS; i++)
            if (wa_log[(start+i) % LOGN] != base + i || wd_log[(start+i) % LOGN] != 32'h20) bad++;
        check({tag, "_clear_bad"}, 32'(bad), 32'(0));
        compare_state(tag);
    endtask

    function automatic int pick_param();
        int k;
        k = int'($urandom_range(0, 3));
        if (k == 0) return 0;
        if (k == 1) return int'($urandom_range(1, 5));
        if (k == 2) return int'($urandom_range(0, 255));
        return int'($urandom_range(20, 90));
    endfunction

    function automatic int pick_char();
        int k;
        k = int'($urandom_range(0, 9));
        if (k < 6)  return int'($urandom_range(32, 126));
        if (k == 6) return 13;
        if (k == 7) return 10;
        if (k == 8) return 8;
        return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(127, 255));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, yaddr, ok;
        logic [3:0] t;

        // Reset state
        repeat (3) tick();
        check("rst_ramWe", 32'(ramWe), 0);
        check("rst_ramAddr", 32'(ramAddr), 0);
        check("rst_ramData", 32'(ramData), 0);
        check("rst_row", 32'(cursorRow), 0);
        check("rst_col", 32'(cursorCol), 0);
        check("rst_top", 32'(topLine), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst = 1'b1;
        repeat (2) tick();

        // INPUT 'A': busy at T+1, single write at T+2
        send(C_INPUT, 0, 0, 8'h41);
        model(C_INPUT, 0, 0, 8'h41);
        check("a_busy_t1", 32'(busy), 1);
        check("a_we_t1", 32'(ramWe), 0);
        tick();
        check("a_we_t2", 32'(ramWe), 1);
        check("a_addr_t2", 32'(ramAddr), 0);
        check("a_data_t2", 32'(ramData), 32'h41);
        check("a_col_t2", 32'(cursorCol), 1);
        check("a_busy_t2", 32'(busy), 0);
        tick();
        check("a_we_t3", 32'(ramWe), 0);
        compare_state("a");

        // Cursor addressing with clamping
        run_cmd("cup_5_10", C_CUP, 5, 10, 0);
        check("cup_5_10_rowc", 32'(cursorRow), 4);
        check("cup_5_10_colc", 32'(cursorCol), 9);
        run_cmd("cup_0_200", C_CUP, 0, 200, 0);
        check("cup_0_200_rowc", 32'(cursorRow), 0);
        check("cup_0_200_colc", 32'(cursorCol), 79);
        run_cmd("cup_5_1", C_CUP, 5, 1, 0);
        run_cmd("cuu_30", C_CUU, 30, 0, 0);
        check("cuu_30_rowc", 32'(cursorRow), 0);

        // Scroll up from the bottom row clears physical row 0
        run_cmd("cup_bottom", C_CUP, 24, 1, 0);
        scroll_burst("ind_scroll", C_IND, 0);
        check("ind_scroll_topc", 32'(topLine), 1);
        check("ind_scroll_rowc", 32'(cursorRow), 23);

        // Scroll down from row 0 with topLine 0 clears the last physical row
        run_cmd("cup_top", C_CUP, 1, 1, 0);
        run_cmd("ri_to0", C_RI, 0, 0, 0);
        scroll_burst("ri_scroll", C_RI, 1840);
        check("ri_scroll_topc", 32'(topLine), 23);

        // Command burst while clearing: first buffered, rest dropped
        run_cmd("ovf_setup", C_CUP, 24, 1, 0);
        send(C_IND, 0, 0, 0);
        model(C_IND, 0, 0, 0);
        repeat (5) tick();
        check("ovf_before", 32'(overflow), 0);
        commandReady = 1'b1;
        commandType = C_CUF; Pn1 = 8'd3; tick();
        commandType = C_CUF; Pn1 = 8'd5; tick();
        commandType = C_CUB; Pn1 = 8'd1; tick();
        commandReady = 1'b0;
        model(C_CUF, 3, 0, 0);
        check("ovf_after", 32'(overflow), 1);
        wait_idle("ovf_drain");
        compare_state("ovf_drain");
        check("ovf_colc", 32'(cursorCol), 3);
        run_cmd("ovf_later", C_CUD, 2, 0, 0);
        check("ovf_sticky", 32'(overflow), 1);

        // Last-column printable behaviour
        run_cmd("wrap_pos", C_CUP, 24, 80, 0);
        run_cmd("wrap_x", C_INPUT, 0, 0, 8'h58);
        check("wrap_x_colc", 32'(cursorCol), 79);
        run_cmd("wrap_y", C_INPUT, 0, 0, 8'h59);
`ifdef AUTO_WRAP_EN
        check("wrap_y_colc", 32'(cursorCol), 1);
        yaddr = ((ROWS - 1 + m_top) % ROWS) * COLS;
`else
        check("wrap_y_colc", 32'(cursorCol), 79);
        yaddr = ((ROWS - 1 + m_top) % ROWS) * COLS + COLS - 1;
`endif
        check("wrap_y_cell", 32'(ram_obs[yaddr]), 32'h59);

        // Randomized command stream against the model
        for (int i = 0; i < 150; i++) begin
            t = 4'($urandom_range(0, 8));
            if ($urandom_range(0, 2) == 0) t = C_INPUT;
            run_cmd($sformatf("rnd%0d", i), t, pick_param(), pick_param(), pick_char());
            repeat (int'($urandom_range(0, 2))) tick();
        end

        // Reset in the middle of a clear burst
        run_cmd("abort_setup", C_CUP, 24, 1, 0);
        send(C_IND, 0, 0, 0);
        repeat (10) tick();
        wc = wr_count;
        ok = (ramWe === 1'b1) ? 1 : 0;
        check("abort_mid_clear", 32'(ok), 1);
        rst = 1'b0;
        tick();
        check("abort_we", 32'(ramWe), 0);
        repeat (3) tick();
        check("abort_nwrites", 32'(wr_count), 32'(wc));
        check("abort_busy", 32'(busy), 0);
        check("abort_ovf", 32'(overflow), 0);
        check("abort_top", 32'(topLine), 0);
        check("abort_row", 32'(cursorRow), 0);
        rst = 1'b1;
        tick();
        wc = wr_count;
        send(C_INPUT, 0, 0, 8'h42);
        wait_idle("post_rst");
        check("post_rst_nwrites", 32'(wr_count - wc), 1);
        check("post_rst_addr", 32'(wa_log[wc % LOGN]), 0);
        check("post_rst_data", 32'(wd_log[wc % LOGN]), 32'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/command_executor.md
# command_executor

Consumes decoded commands from the escape-sequence parser and executes them against the character text buffer. It owns the cursor (row, column) and the scroll origin. It writes printable characters into the text RAM and performs line scrolling with clearing of the exposed line. It sits between the parser and the text-RAM write port; the display scanner reads `topLine` to map screen rows to RAM rows.

## Interface
- `COLS`, 80, screen columns; `COL_W = $clog2(COLS)`
- `ROWS`, 24, screen rows; `ROW_W = $clog2(ROWS)`; `ADDR_W = $clog2(ROWS*COLS)`
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-low
- `commandReady` in 1: one-cycle strobe, command valid
- `commandType` in CommandsType: INPUT, IND, NEL, RI, CUU, CUD, CUF, CUB, CUP (from DataType.svh)
- `Pn1`, `Pn2` in 8 each: numeric parameters
- `Pchar` in 8: character for INPUT
- `ramWe` out 1: text RAM write enable
- `ramAddr` out ADDR_W: physical address = `((row+topLine) mod ROWS)*COLS + col`
- `ramData` out 8: write data
- `cursorRow` out ROW_W; `cursorCol` out COL_W: logical cursor position
- `topLine` out ROW_W: physical RAM row shown as screen row 0
- `busy` out 1: buffer occupied or FSM not IDLE
- `overflow` out 1: sticky; a command was dropped

## Operation
- One-entry command buffer. `commandReady` with the buffer empty captures type/Pn1/Pn2/Pchar. With the buffer full, the command is dropped and `overflow` is set.
- FSM states:
  - IDLE: buffer valid -> EXEC.
  - EXEC: updates the cursor, issues a write if any, frees the buffer. Goes to CLEAR if a scroll occurred, else IDLE.
  - CLEAR: writes 0x20 to columns 0..COLS-1 of the newly exposed physical row, one per cycle, then -> IDLE.
- Parameter rule: n = (Pn==0) ? 1 : Pn. All arithmetic is done in 9 bits, then clamped; no wrap-around.
- INPUT:
  - 0x20..0x7E: write Pchar at the cursor, then col+1. At col==COLS-1 the column stays put (see Configuration).
  - 0x0D: col=0.
  - 0x0A: same as IND.
  - 0x08: col=max(col-1,0).
  - All other codes are ignored, with no write.
- CUU: row=max(row-n,0). CUD: row=min(row+n,ROWS-1).
- CUF: col=min(col+n,COLS-1). CUB: col=max(col-n,0).
- CUP: row=min(n1,ROWS)-1, col=min(n2,COLS)-1.
- IND:
  - row<ROWS-1: row+1.
  - Else scroll up: topLine=(topLine+1) mod ROWS; clear physical row = new bottom line. Cursor row is unchanged.
- NEL: col=0, then IND.
- RI:
  - row>0: row-1.
  - Else scroll down: topLine = topLine==0 ? ROWS-1 : topLine-1; clear new top line.
- Any cursor-movement command, CR, or BS clears the wrap-pending flag.

## Timing
- Reset: FSM IDLE, buffer empty, cursorRow=0, cursorCol=0, topLine=0, ramWe=0, ramAddr=0, ramData=0, busy=0, overflow=0, wrap-pending=0. The RAM is not cleared by this block.
- `commandReady` at cycle T: the buffer is loaded at the T edge, `busy`=1 from T+1, and EXEC runs in T+1.
- All outputs are registered. During T+2:
  - The character write appears: ramWe=1 for exactly one cycle, ramAddr = the pre-move cursor.
  - The new cursorRow/cursorCol/topLine are visible.
- Without a scroll, `busy` is 0 at T+2.
- With a scroll, CLEAR writes during cycles T+2..T+COLS+1 at consecutive addresses of a single physical row, and `busy` drops at T+COLS+2. The wrap into that row's addresses never crosses into another row.
- A new command may be accepted on any cycle the buffer is empty, including during CLEAR. It executes after CLEAR completes.
- `rst` mid-CLEAR aborts immediately; no further writes occur.

## Configuration
- `AUTO_WRAP_EN` defined:
  - A printable at col==COLS-1 is written there and sets wrap-pending; the column stays.
  - The next printable first does col=0 plus IND (scrolling if on the last row), then writes at the new position.
- `AUTO_WRAP_EN` undefined: wrap-pending does not exist; printables at col==COLS-1 overwrite that cell repeatedly.

## Test plan
- Reset, then INPUT 'A' (0x41) -> one cycle ramWe=1, ramAddr=0, ramData=0x41; cursorCol=1 at T+2, busy=0.
- CUP Pn1=5, Pn2=10 -> row=4, col=9. CUP Pn1=0, Pn2=200 -> row=0, col=79. CUU Pn1=30 from row 4 -> row=0.
- Cursor at row 23, IND -> topLine=1, row stays 23. Exactly 80 writes of 0x20 at addresses 0..79; busy high for 81 cycles.
- topLine=0, row 0, RI -> topLine=23; 80 writes at addresses 1840..1919.
- Three commandReady strobes on consecutive cycles while in CLEAR -> first buffered, second and third dropped, overflow=1 until reset.
- With AUTO_WRAP_EN: col 79, row 23, INPUT 'X' then 'Y' -> 'X' at col 79; then scroll, clear, 'Y' at col 0 of new bottom row, col=1. Without AUTO_WRAP_EN: 'Y' overwrites col 79.
